// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder controller.
// One full_adder is reused over WIDTH cycles to form a + b + c_in, LSB first,
// with the carry held in a flop between bit-steps.
//
// Ports:
//   clk_in, rst_n_in           clock (rising edge), async active-low reset
//   a_in, b_in, c_in           operands, sampled on in_valid_in & in_ready_out
//   in_valid_in / in_ready_out input handshake (ready only in IDLE)
//   sum_out, carry_out         registered result, held until the next result
//   out_valid_out/out_ready_in output handshake (valid only in DONE)
//   busy_out                   high while bit-steps are running

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic             busy_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             last_step;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the LSB.
  // Written as a widened shift so WIDTH=1 needs no special case.
  assign sum_nxt = WIDTH'({fa_s, sum_sh} >> 1);

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_in)  state_nxt = RUN;
      RUN:     if (last_step)    state_nxt = DONE;
      DONE:    if (out_ready_in) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready_out  = 1'b0;
    busy_out      = 1'b0;
    out_valid_out = 1'b0;
    case (state)
      IDLE:    in_ready_out  = 1'b1;
      RUN:     busy_out      = 1'b1;
      DONE:    out_valid_out = 1'b1;
      default: in_ready_out  = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_in) begin
          a_sh    <= a_in;
          b_sh    <= b_in;
          carry_q <= c_in;
          cnt     <= '0;
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= sum_nxt;
          carry_q <= fa_co;
          cnt     <= cnt + CNT_W'(1);
          if (last_step) begin
            sum_out   <= sum_nxt;
            carry_out <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       c4 = 0, iv4 = 0, ir4, co4, ov4, or4 = 0, busy4;
  // WIDTH=1 instance
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic       c1 = 0, iv1 = 0, ir1, co1, ov1, or1 = 0, busy1;

  int checks = 0, errors = 0;
  int ih4 = 0, oh4 = 0, ih1 = 0, oh1 = 0;

  serial_adder_ctrl #(.WIDTH(4)) u4 (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a4), .b_in(b4), .c_in(c4),
    .in_valid_in(iv4), .in_ready_out(ir4), .sum_out(s4), .carry_out(co4),
    .out_valid_out(ov4), .out_ready_in(or4), .busy_out(busy4));

  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .a_in(a1), .b_in(b1), .c_in(c1),
    .in_valid_in(iv1), .in_ready_out(ir1), .sum_out(s1), .carry_out(co1),
    .out_valid_out(ov1), .out_ready_in(or1), .busy_out(busy1));

  // Handshake counters (sampled pre-edge)
  always @(posedge clk) if (rst_n) begin
    if (iv4 && ir4) ih4++;
    if (ov4 && or4) oh4++;
    if (iv1 && ir1) ih1++;
    if (ov1 && or1) oh1++;
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  // One full transaction on the WIDTH=4 instance, compared with plain addition.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c, input int stall);
    logic [4:0] exp;
    int n;
    exp = a + b + c;
    a4 = a; b4 = b; c4 = c; iv4 = 1; or4 = 0;
    n = 0;
    while (ir4 !== 1'b1 && n < 50) begin step; n++; end
    step; iv4 = 0;
    n = 0;
    while (ov4 !== 1'b1 && n < 50) begin step; n++; end
    checks++;
    if (n != 4) begin errors++; $display("FAIL run4_latency got %0d want 4", n); end
    checks++;
    if ({co4, s4} !== exp) begin errors++;
      $display("FAIL run4_sum a=%h b=%h c=%b got %h want %h", a, b, c, {co4, s4}, exp); end
    repeat (stall) step;
    or4 = 1; step; or4 = 0;
    checks++;
    if (ov4 !== 1'b0) begin errors++; $display("FAIL run4_release got ov=%b want 0", ov4); end
  endtask

  task automatic run1(input logic a, input logic b, input logic c, input int stall);
    logic [1:0] exp;
    int n;
    exp = 2'(a) + 2'(b) + 2'(c);
    a1 = a; b1 = b; c1 = c; iv1 = 1; or1 = 0;
    n = 0;
    while (ir1 !== 1'b1 && n < 50) begin step; n++; end
    step; iv1 = 0;
    n = 0;
    while (ov1 !== 1'b1 && n < 50) begin step; n++; end
    checks++;
    if (n != 1) begin errors++; $display("FAIL run1_latency got %0d want 1", n); end
    checks++;
    if ({co1, s1} !== exp) begin errors++;
      $display("FAIL run1_sum a=%b b=%b c=%b got %b want %b", a, b, c, {co1, s1}, exp); end
    repeat (stall) step;
    or1 = 1; step; or1 = 0;
    checks++;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL run1_release got ov=%b want 0", ov1); end
  endtask

  task automatic test_reset;
    #1 rst_n = 0;
    #2;
    checks++;
    if ({ir4, busy4, ov4, s4, co4} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin errors++;
      $display("FAIL reset_w4 got ir=%b busy=%b ov=%b s=%h co=%b want 1 0 0 0 0", ir4, busy4, ov4, s4, co4); end
    checks++;
    if ({ir1, busy1, ov1, s1, co1} !== 5'b10000) begin errors++;
      $display("FAIL reset_w1 got %b want 10000", {ir1, busy1, ov1, s1, co1}); end
    step; step;
    rst_n = 1;
    step;
  endtask

  task automatic test_basic;
    int bad;
    a4 = 4'h5; b4 = 4'h3; c4 = 0; or4 = 1; iv4 = 1;
    step; iv4 = 0;
    checks++;
    if (busy4 !== 1'b1 || ir4 !== 1'b0) begin errors++;
      $display("FAIL basic_run_entry got busy=%b ir=%b want 1 0", busy4, ir4); end
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      step;
      if (i < 4 && (ov4 !== 1'b0 || busy4 !== 1'b1)) bad++;
      if (i == 4 && (ov4 !== 1'b1 || busy4 !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_timing got %0d bad cycles want 0", bad); end
    checks++;
    if ({co4, s4} !== 5'h08) begin errors++; $display("FAIL basic_sum got %h want 08", {co4, s4}); end
    step;
    checks++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1 || s4 !== 4'h8) begin errors++;
      $display("FAIL basic_idle got ov=%b ir=%b s=%h want 0 1 8", ov4, ir4, s4); end
    or4 = 0;
  endtask

  task automatic test_carry;
    run4(4'hF, 4'h1, 1'b0, 0);
    run4(4'hF, 4'hF, 1'b1, 1);
  endtask

  task automatic test_backpressure;
    int n;
    a4 = 4'h6; b4 = 4'h7; c4 = 0; iv4 = 1; or4 = 0;
    step; iv4 = 0;
    n = 0;
    while (ov4 !== 1'b1 && n < 50) begin step; n++; end
    a4 = 4'h9; b4 = 4'h4; c4 = 1; iv4 = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if ({ov4, ir4, co4, s4} !== {1'b1, 1'b0, 1'b0, 4'hD}) begin errors++;
        $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b co=%b s=%h want 1 0 0 d", i, ov4, ir4, co4, s4); end
    end
    or4 = 1; step; or4 = 0;
    checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++;
      $display("FAIL bp_idle got ir=%b ov=%b want 1 0", ir4, ov4); end
    step; iv4 = 0;
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL bp_accept got busy=%b want 1", busy4); end
    n = 0;
    while (ov4 !== 1'b1 && n < 50) begin step; n++; end
    checks++;
    if ({co4, s4} !== 5'h0E) begin errors++; $display("FAIL bp_sum got %h want 0e", {co4, s4}); end
    or4 = 1; step; or4 = 0;
  endtask

  task automatic test_ignore_midrun;
    int n, extra;
    a4 = 4'h1; b4 = 4'h1; c4 = 0; iv4 = 1; or4 = 0;
    step; iv4 = 0;
    step;
    a4 = 4'h2; b4 = 4'h2; iv4 = 1;
    n = 0;
    while (ov4 !== 1'b1 && n < 50) begin step; n++; end
    iv4 = 0;
    checks++;
    if ({co4, s4} !== 5'h02) begin errors++; $display("FAIL midrun_sum got %h want 02", {co4, s4}); end
    or4 = 1; step; or4 = 0;
    extra = 0;
    repeat (8) begin step; if (ov4 !== 1'b0 || busy4 !== 1'b0) extra++; end
    checks++;
    if (extra != 0 || ir4 !== 1'b1) begin errors++;
      $display("FAIL midrun_extra got %0d active cycles ir=%b want 0 1", extra, ir4); end
  endtask

  task automatic test_async_reset;
    a4 = 4'h3; b4 = 4'h5; c4 = 0; iv4 = 1; or4 = 0;
    step; iv4 = 0;
    step; step;
    #3 rst_n = 0;
    #1;
    checks++;
    if ({ir4, busy4, ov4, s4, co4} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin errors++;
      $display("FAIL async_reset got ir=%b busy=%b ov=%b s=%h co=%b want 1 0 0 0 0", ir4, busy4, ov4, s4, co4); end
    step;
    rst_n = 1;
    step;
    checks++;
    if (ov4 !== 1'b0 || busy4 !== 1'b0) begin errors++;
      $display("FAIL async_discard got ov=%b busy=%b want 0 0", ov4, busy4); end
    run4(4'h7, 4'h9, 1'b1, 0);
  endtask

  task automatic test_width1;
    for (int i = 0; i < 8; i++) run1(i[2], i[1], i[0], i % 2);
  endtask

  task automatic test_random;
    ih4 = 0; oh4 = 0; ih1 = 0; oh1 = 0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) step;
      run4(4'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) step;
      run1(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    checks++;
    if (ih4 != 1000 || oh4 != 1000) begin errors++;
      $display("FAIL rand_hs_w4 got in=%0d out=%0d want 1000 1000", ih4, oh4); end
    checks++;
    if (ih1 != 1000 || oh1 != 1000) begin errors++;
      $display("FAIL rand_hs_w1 got in=%0d out=%0d want 1000 1000", ih1, oh1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_backpressure;
    test_ignore_midrun;
    test_async_reset;
    test_width1;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
